// File: rtl/burst_pattern_gen_pkg.sv
package burst_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'b00,
    MODE_PRBS7  = 2'b01,
    MODE_ONES   = 2'b10,
    MODE_ZEROS  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_SEND,
    S_DONE
  } state_e;

  // x^7 + x^6 + 1, shifting toward bit 0
  localparam int unsigned PRBS7_TAP_HI = 6;
  localparam int unsigned PRBS7_TAP_LO = 0;

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO], s[6:1]};
  endfunction

  function automatic logic pattern_bit(input mode_e m, input logic sq, input logic prbs);
    logic b;
    b = 1'b0;
    case (m)
      MODE_SQUARE: b = sq;
      MODE_PRBS7:  b = prbs;
      MODE_ONES:   b = 1'b1;
      default:     b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/burst_pattern_gen_prbs7.sv
module prbs7_lfsr
  import burst_pattern_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] seed,
  input  logic       adv,
  output logic       bit_out
);

  logic [6:0] state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (adv) begin
      state <= prbs7_step(state);
    end
  end

  assign bit_out = state[0];

endmodule

// File: rtl/burst_pattern_gen.sv
module burst_pattern_gen
  import burst_pattern_gen_pkg::*;
#(
  parameter  int unsigned CHANNELS  = 2,
  parameter  int unsigned BURST_LEN = 1000,
  parameter  int unsigned DIV       = 2,
  parameter  logic [6:0]  SEED      = 7'h01,
  localparam int unsigned CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                run,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] ch_en,
  output logic                enable,
  output logic                busy,
  output logic                done,
  output logic [CHANNELS-1:0] tx,
  output logic [CHANNELS-1:0] ref_bits,
  output logic [CNT_W-1:0]    bit_cnt
);

  localparam int unsigned       DIV_W    = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BURST_LEN - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);

  if (SEED == 7'd0) begin : g_bad_seed
    $error("burst_pattern_gen: SEED must be nonzero");
  end

  state_e              state;
  mode_e               mode_l;
  logic [CHANNELS-1:0] ch_en_l;
  logic [DIV_W-1:0]    div_cnt;
  logic                sq;
  logic                prbs_bit;
  logic                bit_stb;
  logic                lfsr_load;
  logic                lfsr_adv;

  assign bit_stb   = (div_cnt == DIV_LAST);
  assign lfsr_load = (state == S_ARM);
  assign lfsr_adv  = (state == S_SEND) && bit_stb && !abort;
  assign busy      = (state != S_IDLE);
  assign ref_bits  = tx;

  // LFSR runs one bit ahead of the wire so tx can be registered:
  // bit 0 comes straight from SEED, the LFSR is loaded with the next state.
  prbs7_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed    (prbs7_step(SEED)),
    .adv     (lfsr_adv),
    .bit_out (prbs_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mode_l  <= MODE_SQUARE;
      ch_en_l <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sq      <= 1'b0;
      enable  <= 1'b0;
      done    <= 1'b0;
      tx      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done    <= 1'b0;
          enable  <= 1'b0;
          tx      <= '0;
          bit_cnt <= '0;
          div_cnt <= '0;
          if ((start || run) && !abort) begin
            state <= S_ARM;
          end
        end
        S_ARM: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            mode_l  <= mode_e'(mode);
            ch_en_l <= ch_en;
            div_cnt <= '0;
            bit_cnt <= '0;
            sq      <= 1'b1;
            enable  <= 1'b1;
            tx      <= {CHANNELS{pattern_bit(mode_e'(mode), 1'b1, SEED[0])}} & ch_en;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (abort) begin
            state   <= S_IDLE;
            enable  <= 1'b0;
            tx      <= '0;
            bit_cnt <= '0;
          end else if (bit_stb) begin
            div_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              state  <= S_DONE;
              done   <= 1'b1;
              enable <= 1'b0;
              tx     <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              sq      <= ~sq;
              tx      <= {CHANNELS{pattern_bit(mode_l, ~sq, prbs_bit)}} & ch_en_l;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          bit_cnt <= '0;
          if (abort) begin
            state <= S_IDLE;
          end else if (run) begin
            state <= S_ARM;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_pattern_gen.sv
module tb_burst_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       run;
  logic       abort;
  logic [1:0] mode;
  logic [1:0] ch_en;

  always #5 clk = ~clk;

  logic       en_a, busy_a, done_a;
  logic [1:0] tx_a, rf_a;
  logic [3:0] cnt_a;
  logic       en_b, busy_b, done_b;
  logic [1:0] tx_b, rf_b;
  logic [4:0] cnt_b;
  logic       en_c, busy_c, done_c;
  logic [1:0] tx_c, rf_c;
  logic [0:0] cnt_c;

  burst_pattern_gen #(.CHANNELS(2), .BURST_LEN(8), .DIV(2), .SEED(7'h01)) dut_a (
    .clk(clk), .rst(rst), .start(start), .run(run), .abort(abort), .mode(mode), .ch_en(ch_en),
    .enable(en_a), .busy(busy_a), .done(done_a), .tx(tx_a), .ref_bits(rf_a), .bit_cnt(cnt_a)
  );

  burst_pattern_gen #(.CHANNELS(2), .BURST_LEN(20), .DIV(1), .SEED(7'h5A)) dut_b (
    .clk(clk), .rst(rst), .start(start), .run(run), .abort(abort), .mode(mode), .ch_en(ch_en),
    .enable(en_b), .busy(busy_b), .done(done_b), .tx(tx_b), .ref_bits(rf_b), .bit_cnt(cnt_b)
  );

  burst_pattern_gen #(.CHANNELS(2), .BURST_LEN(1), .DIV(1), .SEED(7'h33)) dut_c (
    .clk(clk), .rst(rst), .start(start), .run(run), .abort(abort), .mode(mode), .ch_en(ch_en),
    .enable(en_c), .busy(busy_c), .done(done_c), .tx(tx_c), .ref_bits(rf_c), .bit_cnt(cnt_c)
  );

  logic        en_o[3], busy_o[3], done_o[3];
  logic [1:0]  tx_o[3], rf_o[3];
  int unsigned cnt_o[3];

  assign en_o[0] = en_a;   assign busy_o[0] = busy_a; assign done_o[0] = done_a;
  assign en_o[1] = en_b;   assign busy_o[1] = busy_b; assign done_o[1] = done_b;
  assign en_o[2] = en_c;   assign busy_o[2] = busy_c; assign done_o[2] = done_c;
  assign tx_o[0] = tx_a;   assign rf_o[0] = rf_a;     assign cnt_o[0] = 32'(cnt_a);
  assign tx_o[1] = tx_b;   assign rf_o[1] = rf_b;     assign cnt_o[1] = 32'(cnt_b);
  assign tx_o[2] = tx_c;   assign rf_o[2] = rf_c;     assign cnt_o[2] = 32'(cnt_c);

  // Reference model: each DUT is tracked only by how many cycles have passed
  // since its burst began (ph = 0 is the arming cycle), plus the latched settings.
  int unsigned blen[3]  = '{8, 20, 1};
  int unsigned dv[3]    = '{2, 1, 1};
  logic [6:0]  seeds[3] = '{7'h01, 7'h5A, 7'h33};
  bit          prbs[3][64];
  bit          act[3];
  int unsigned ph[3];
  logic [1:0]  lmode[3];
  logic [1:0]  lchen[3];

  int checks = 0;
  int errors = 0;

  function automatic bit pat(int d, int unsigned i);
    case (lmode[d])
      2'b00:   return (i % 2) == 0;
      2'b01:   return prbs[d][i];
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string tag, int d, int unsigned got, int unsigned exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s dut%0d: observed %0d expected %0d", tag, d, got, exp);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        act[d] = 1'b0;
      end else if (act[d]) begin
        if (abort) begin
          act[d] = 1'b0;
        end else begin
          ph[d]++;
          if (ph[d] == 1) begin
            lmode[d] = mode;
            lchen[d] = ch_en;
          end
          if (ph[d] == blen[d] * dv[d] + 2) begin
            if (run) ph[d] = 0;
            else act[d] = 1'b0;
          end
        end
      end else if ((start || run) && !abort) begin
        act[d] = 1'b1;
        ph[d]  = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      logic        e_en, e_busy, e_done;
      logic [1:0]  e_tx;
      int unsigned e_cnt;
      int unsigned ld;
      bit          cnt_valid;
      ld        = blen[d] * dv[d];
      e_en      = 1'b0;
      e_busy    = act[d];
      e_done    = 1'b0;
      e_tx      = 2'b00;
      e_cnt     = 0;
      cnt_valid = 1'b1;
      if (act[d] && ph[d] >= 1 && ph[d] <= ld) begin
        e_en  = 1'b1;
        e_cnt = (ph[d] - 1) / dv[d];
        e_tx  = {2{pat(d, e_cnt)}} & lchen[d];
      end else if (act[d] && ph[d] == ld + 1) begin
        e_done    = 1'b1;
        cnt_valid = 1'b0;
      end
      chk("enable", d, 32'(en_o[d]), 32'(e_en));
      chk("busy", d, 32'(busy_o[d]), 32'(e_busy));
      chk("done", d, 32'(done_o[d]), 32'(e_done));
      chk("tx", d, 32'(tx_o[d]), 32'(e_tx));
      chk("ref", d, 32'(rf_o[d]), 32'(e_tx));
      if (cnt_valid) chk("bit_cnt", d, cnt_o[d], e_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    run   = 1'b0;
    abort = 1'b0;
    mode  = 2'b00;
    ch_en = 2'b11;
    for (int d = 0; d < 3; d++) begin
      act[d]   = 1'b0;
      ph[d]    = 0;
      lmode[d] = 2'b00;
      lchen[d] = 2'b00;
      for (int i = 0; i < 7; i++) prbs[d][i] = seeds[d][i];
      for (int i = 7; i < 64; i++) prbs[d][i] = prbs[d][i-1] ^ prbs[d][i-7];
    end

    // reset state
    #1;
    check_all();
    tick();
    tick();
    rst = 1'b0;

    // single square burst on both lanes
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();

    // PRBS7 burst; settings scrambled after arming
    mode  = 2'b01;
    ch_en = 2'b11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (28) begin
      mode  = 2'($urandom);
      ch_en = 2'($urandom);
      tick();
    end

    // continuous mode for several bursts, then drop run mid-burst
    mode  = 2'b00;
    ch_en = 2'b11;
    run   = 1'b1;
    repeat (58) tick();
    run = 1'b0;
    repeat (30) tick();

    // abort while bit 3 of the 8-bit burst is on the wire
    mode  = 2'b01;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && !(act[0] && ph[0] == 7); i++) tick();
    if (!(act[0] && ph[0] == 7)) begin
      errors++;
      $error("FAIL abort_wait: observed ph=%0d expected ph=7", ph[0]);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (25) tick();

    // all-ones on lane 0 only, with mid-burst input churn
    mode  = 2'b10;
    ch_en = 2'b01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (24) begin
      mode  = 2'($urandom);
      ch_en = 2'($urandom);
      start = ($urandom_range(0, 3) == 0);
      tick();
    end
    start = 1'b0;
    repeat (25) tick();

    // asynchronous reset between edges during a burst
    mode  = 2'b00;
    ch_en = 2'b11;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) act[d] = 1'b0;
    check_all();
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // randomized traffic
    repeat (3000) begin
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 3) == 0) ch_en = 2'($urandom);
      tick();
    end
    start = 1'b0;
    run   = 1'b0;
    abort = 1'b0;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
